// File: rtl/logic_axi4_stream_downsizer_if.sv
// AXI4-Stream bundle shared by the downsizer's Rx and Tx sides.
// The master drives everything except tready.
interface logic_axi4_stream_downsizer_if #(
    parameter int DATA_BYTES = 4,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic [USER_WIDTH-1:0]   tuser;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [ID_WIDTH-1:0]     tid;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tstrb, tuser, tdest, tid, tlast,
                    input  tready);
    modport slave  (input  tvalid, tdata, tkeep, tstrb, tuser, tdest, tid, tlast,
                    output tready);
endinterface

// File: rtl/logic_axi4_stream_downsizer.sv
// AXI4-Stream downsizer: splits each wide Rx beat into RATIO narrow Tx beats,
// least-significant segment first, dropping trailing segments with no kept bytes.
module logic_axi4_stream_downsizer #(
    parameter int RX_TDATA_BYTES = 8,
    parameter int TX_TDATA_BYTES = 4,
    parameter int TX_TUSER_WIDTH = 1,
    parameter int RX_TUSER_WIDTH = (RX_TDATA_BYTES / TX_TDATA_BYTES) * TX_TUSER_WIDTH,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int USE_TLAST      = 1,
    parameter int USE_TKEEP      = 1,
    parameter int USE_TSTRB      = 1
) (
    input logic                            aclk,
    input logic                            areset,
    logic_axi4_stream_downsizer_if.slave   rx,
    logic_axi4_stream_downsizer_if.master  tx
);
    localparam int RATIO = RX_TDATA_BYTES / TX_TDATA_BYTES;
    localparam int SEG_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int TXD   = TX_TDATA_BYTES * 8;
    localparam int RXD   = RX_TDATA_BYTES * 8;

    if (RATIO < 2 || RATIO * TX_TDATA_BYTES != RX_TDATA_BYTES ||
        RX_TUSER_WIDTH != RATIO * TX_TUSER_WIDTH) begin : g_bad_cfg
        $error("logic_axi4_stream_downsizer: inconsistent width parameters");
    end

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t                    state_q, state_d;
    logic [RXD-1:0]            data_q, data_d;
    logic [RX_TDATA_BYTES-1:0] keep_q, keep_d;
    logic [RX_TDATA_BYTES-1:0] strb_q, strb_d;
    logic [RX_TUSER_WIDTH-1:0] user_q, user_d;
    logic [TDEST_WIDTH-1:0]    dest_q, dest_d;
    logic [TID_WIDTH-1:0]      id_q, id_d;
    logic                      rxlast_q, rxlast_d;
    logic                      tlast_q, tlast_d;
    logic [SEG_W-1:0]          seg_q, seg_d;
    logic [SEG_W-1:0]          last_seg_q, last_seg_d;

    logic [SEG_W-1:0]          last_seg_calc;
    logic                      at_last, tx_hs, rx_ready, rx_acc;

    // Highest segment with any kept byte; a null beat still yields segment 0.
    always_comb begin
        last_seg_calc = '0;
        if (USE_TKEEP == 0) begin
            last_seg_calc = SEG_W'(RATIO - 1);
        end else begin
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (|rx.tkeep[k*TX_TDATA_BYTES +: TX_TDATA_BYTES]) begin
                    last_seg_calc = SEG_W'(k);
                end
            end
        end
    end

    always_comb begin
        at_last  = (seg_q == last_seg_q);
        tx_hs    = (state_q == BUSY) && tx.tready;
        rx_ready = !areset && ((state_q == EMPTY) || (tx.tready && at_last));
        rx_acc   = rx.tvalid && rx_ready;

        state_d    = state_q;
        data_d     = data_q;
        keep_d     = keep_q;
        strb_d     = strb_q;
        user_d     = user_q;
        dest_d     = dest_q;
        id_d       = id_q;
        rxlast_d   = rxlast_q;
        tlast_d    = tlast_q;
        seg_d      = seg_q;
        last_seg_d = last_seg_q;

        if (rx_acc) begin
            state_d    = BUSY;
            data_d     = rx.tdata;
            keep_d     = (USE_TKEEP != 0) ? rx.tkeep : '1;
            strb_d     = (USE_TSTRB != 0) ? rx.tstrb : '1;
            user_d     = rx.tuser;
            dest_d     = rx.tdest;
            id_d       = rx.tid;
            rxlast_d   = (USE_TLAST != 0) && rx.tlast;
            seg_d      = '0;
            last_seg_d = last_seg_calc;
            tlast_d    = rxlast_d && (last_seg_calc == '0);
        end else if (tx_hs) begin
            if (at_last) begin
                state_d = EMPTY;
            end else begin
                // Held beat shifts down so the current segment always sits in the low lanes.
                data_d  = data_q >> TXD;
                keep_d  = keep_q >> TX_TDATA_BYTES;
                strb_d  = strb_q >> TX_TDATA_BYTES;
                user_d  = user_q >> TX_TUSER_WIDTH;
                seg_d   = seg_q + SEG_W'(1);
                tlast_d = rxlast_q && ((seg_q + SEG_W'(1)) == last_seg_q);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            data_q     <= '0;
            keep_q     <= '0;
            strb_q     <= '0;
            user_q     <= '0;
            dest_q     <= '0;
            id_q       <= '0;
            rxlast_q   <= 1'b0;
            tlast_q    <= 1'b0;
            seg_q      <= '0;
            last_seg_q <= '0;
        end else begin
            data_q     <= data_d;
            keep_q     <= keep_d;
            strb_q     <= strb_d;
            user_q     <= user_d;
            dest_q     <= dest_d;
            id_q       <= id_d;
            rxlast_q   <= rxlast_d;
            tlast_q    <= tlast_d;
            seg_q      <= seg_d;
            last_seg_q <= last_seg_d;
        end
    end

    assign rx.tready = rx_ready;
    assign tx.tvalid = (state_q == BUSY);
    assign tx.tdata  = data_q[TXD-1:0];
    assign tx.tkeep  = (USE_TKEEP != 0) ? keep_q[TX_TDATA_BYTES-1:0] : '1;
    assign tx.tstrb  = (USE_TSTRB != 0) ? strb_q[TX_TDATA_BYTES-1:0] : '1;
    assign tx.tuser  = user_q[TX_TUSER_WIDTH-1:0];
    assign tx.tdest  = dest_q;
    assign tx.tid    = id_q;
    assign tx.tlast  = tlast_q;
endmodule

// File: tb/tb_logic_axi4_stream_downsizer.sv
// Scoreboard bench for the downsizer: an 8->4 and a 16->4 instance, directed beats
// with hand-computed Tx segments checked by per-instance monitors.
module tb_logic_axi4_stream_downsizer;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic_axi4_stream_downsizer_if #(.DATA_BYTES(8),  .USER_WIDTH(2), .DEST_WIDTH(1), .ID_WIDTH(1)) rx2 ();
    logic_axi4_stream_downsizer_if #(.DATA_BYTES(4),  .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) tx2 ();
    logic_axi4_stream_downsizer_if #(.DATA_BYTES(16), .USER_WIDTH(4), .DEST_WIDTH(1), .ID_WIDTH(1)) rx4 ();
    logic_axi4_stream_downsizer_if #(.DATA_BYTES(4),  .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) tx4 ();

    logic_axi4_stream_downsizer #(.RX_TDATA_BYTES(8), .TX_TDATA_BYTES(4), .TX_TUSER_WIDTH(1)) dut2 (
        .aclk(aclk), .areset(areset), .rx(rx2), .tx(tx2));
    logic_axi4_stream_downsizer #(.RX_TDATA_BYTES(16), .TX_TDATA_BYTES(4), .TX_TUSER_WIDTH(1)) dut4 (
        .aclk(aclk), .areset(areset), .rx(rx4), .tx(tx4));

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  s;
        logic        u;
        logic        l;
    } beat_t;

    beat_t q2[$];
    beat_t q4[$];
    int    hs2[$];
    beat_t e2v, e4v;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void e2(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                               input logic u, input logic l);
        q2.push_back(beat_t'({d, k, s, u, l}));
    endfunction

    function automatic void e4(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                               input logic u, input logic l);
        q4.push_back(beat_t'({d, k, s, u, l}));
    endfunction

    always @(negedge aclk) begin
        if (!areset && tx2.tvalid && tx2.tready) begin
            hs2.push_back(cyc);
            if (q2.size() == 0) begin
                chk("tx2_unexpected_beat", {tx2.tdata, tx2.tkeep}, 0);
            end else begin
                e2v = q2.pop_front();
                chk("tx2_beat", {tx2.tdata, tx2.tkeep, tx2.tstrb, tx2.tuser, tx2.tlast, tx2.tdest, tx2.tid},
                    {e2v, 2'b11});
            end
        end
    end

    always @(negedge aclk) begin
        if (!areset && tx4.tvalid && tx4.tready) begin
            if (q4.size() == 0) begin
                chk("tx4_unexpected_beat", {tx4.tdata, tx4.tkeep}, 0);
            end else begin
                e4v = q4.pop_front();
                chk("tx4_beat", {tx4.tdata, tx4.tkeep, tx4.tstrb, tx4.tuser, tx4.tlast, tx4.tdest, tx4.tid},
                    {e4v, 2'b11});
            end
        end
    end

    task automatic send2(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                         input logic [1:0] u, input logic l);
        bit ok;
        ok = 0;
        rx2.tdata = d; rx2.tkeep = k; rx2.tstrb = s; rx2.tuser = u; rx2.tlast = l;
        rx2.tvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (rx2.tready) begin ok = 1; break; end
        end
        if (!ok) chk("rx2_accept_timeout", 0, 1);
        @(posedge aclk); #1;
        rx2.tvalid = 1'b0;
    endtask

    task automatic send4(input logic [127:0] d, input logic [15:0] k, input logic [15:0] s,
                         input logic [3:0] u, input logic l);
        bit ok;
        ok = 0;
        rx4.tdata = d; rx4.tkeep = k; rx4.tstrb = s; rx4.tuser = u; rx4.tlast = l;
        rx4.tvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (rx4.tready) begin ok = 1; break; end
        end
        if (!ok) chk("rx4_accept_timeout", 0, 1);
        @(posedge aclk); #1;
        rx4.tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q2.size() == 0 && q4.size() == 0) break;
            @(negedge aclk);
        end
        chk("drain_left", q2.size() + q4.size(), 0);
        @(posedge aclk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rx2.tvalid = 0; rx2.tdata = '0; rx2.tkeep = '0; rx2.tstrb = '0; rx2.tuser = '0;
        rx2.tdest = 1'b1; rx2.tid = 1'b1; rx2.tlast = 0;
        rx4.tvalid = 0; rx4.tdata = '0; rx4.tkeep = '0; rx4.tstrb = '0; rx4.tuser = '0;
        rx4.tdest = 1'b1; rx4.tid = 1'b1; rx4.tlast = 0;
        tx2.tready = 1'b1;
        tx4.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rx2_tready", rx2.tready, 0);
        chk("rst_tx2_tvalid", tx2.tvalid, 0);
        chk("rst_tx2_fields", {tx2.tdata, tx2.tkeep, tx2.tstrb, tx2.tuser, tx2.tlast, tx2.tdest, tx2.tid}, 0);
        chk("rst_tx4_tvalid", tx4.tvalid, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_rx2_tready", rx2.tready, 1);
        chk("post_rst_rx4_tready", rx4.tready, 1);
        @(posedge aclk); #1;

        // Three back-to-back full beats, tlast on the third
        hs2.delete();
        e2(32'h03020100, 4'hF, 4'hF, 1'b0, 1'b0);
        e2(32'h07060504, 4'hF, 4'hF, 1'b1, 1'b0);
        e2(32'h0B0A0908, 4'hF, 4'hC, 1'b1, 1'b0);
        e2(32'h0F0E0D0C, 4'hF, 4'h3, 1'b0, 1'b0);
        e2(32'h13121110, 4'hF, 4'hF, 1'b1, 1'b0);
        e2(32'h17161514, 4'hF, 4'hF, 1'b1, 1'b1);
        send2(64'h0706050403020100, 8'hFF, 8'hFF, 2'b10, 1'b0);
        send2(64'h0F0E0D0C0B0A0908, 8'hFF, 8'h3C, 2'b01, 1'b0);
        send2(64'h1716151413121110, 8'hFF, 8'hFF, 2'b11, 1'b1);
        drain();
        chk("t1_hs_count", hs2.size(), 6);
        chk("t1_no_bubbles", (hs2.size() == 6) ? (hs2[5] - hs2[0]) : 0, 5);

        // Partial tail: upper segment dropped, rx_tready high on the final handshake
        e2(32'h55667788, 4'hF, 4'hF, 1'b1, 1'b1);
        send2(64'h1122334455667788, 8'h0F, 8'h0F, 2'b11, 1'b1);
        @(negedge aclk);
        chk("t2_tvalid", tx2.tvalid, 1);
        chk("t2_rx_tready_same_cycle", rx2.tready, 1);
        @(negedge aclk);
        chk("t2_upper_skipped", tx2.tvalid, 0);
        drain();

        // Null beat
        e2(32'hCAFEF00D, 4'h0, 4'h0, 1'b1, 1'b1);
        send2(64'hDEADBEEFCAFEF00D, 8'h00, 8'h00, 2'b01, 1'b1);
        drain();
        @(negedge aclk);
        chk("t3_single_beat", tx2.tvalid, 0);
        @(posedge aclk); #1;

        // Backpressure 1,0,0,1 with a second beat waiting
        e2(32'h44332211, 4'hF, 4'hF, 1'b0, 1'b0);
        e2(32'h88776655, 4'hF, 4'hF, 1'b1, 1'b1);
        e2(32'h00000001, 4'hF, 4'hF, 1'b0, 1'b0);
        e2(32'h00000002, 4'hF, 4'hF, 1'b0, 1'b1);
        fork
            begin
                send2(64'h8877665544332211, 8'hFF, 8'hFF, 2'b10, 1'b1);
                send2(64'h0000000200000001, 8'hFF, 8'hFF, 2'b00, 1'b1);
            end
            begin
                @(posedge aclk); #1;
                @(posedge aclk); #1;
                tx2.tready = 1'b0;
                repeat (2) begin
                    @(negedge aclk);
                    chk("t4_stall_tvalid", tx2.tvalid, 1);
                    chk("t4_stall_hold", {tx2.tdata, tx2.tkeep, tx2.tuser, tx2.tlast}, {32'h88776655, 4'hF, 1'b1, 1'b1});
                    chk("t4_stall_rx_tready", rx2.tready, 0);
                    @(posedge aclk); #1;
                end
                tx2.tready = 1'b1;
            end
        join
        drain();

        // Ratio 4: one full beat, then the zero-middle / dropped-top case
        e4(32'h03020100, 4'hF, 4'hF, 1'b0, 1'b0);
        e4(32'h07060504, 4'hF, 4'hF, 1'b1, 1'b0);
        e4(32'h0B0A0908, 4'hF, 4'hF, 1'b1, 1'b0);
        e4(32'h0F0E0D0C, 4'hF, 4'hF, 1'b0, 1'b0);
        e4(32'h33221100, 4'hF, 4'hF, 1'b0, 1'b0);
        e4(32'h77665544, 4'h0, 4'h0, 1'b1, 1'b0);
        e4(32'hBBAA9988, 4'hF, 4'hF, 1'b0, 1'b1);
        send4(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 16'hFFFF, 4'b0110, 1'b0);
        send4(128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'h0F0F, 16'h0F0F, 4'b1010, 1'b1);
        drain();
        @(negedge aclk);
        chk("t5_top_dropped", tx4.tvalid, 0);
        @(posedge aclk); #1;

        // Reset after the first segment of a two-segment beat
        e2(32'h44444444, 4'hF, 4'hF, 1'b0, 1'b0);
        send2(64'h5555555544444444, 8'hFF, 8'hFF, 2'b00, 1'b1);
        @(posedge aclk); #1;
        areset = 1'b1;
        tx2.tready = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("t6_tvalid_after_reset", tx2.tvalid, 0);
        chk("t6_fields_after_reset", {tx2.tdata, tx2.tlast}, 0);
        chk("t6_rx_tready_in_reset", rx2.tready, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        tx2.tready = 1'b1;
        @(negedge aclk);
        chk("t6_rx_tready_after_reset", rx2.tready, 1);
        @(posedge aclk); #1;
        e2(32'h66666666, 4'hF, 4'hF, 1'b1, 1'b0);
        e2(32'h77777777, 4'hF, 4'hF, 1'b0, 1'b1);
        send2(64'h7777777766666666, 8'hFF, 8'hFF, 2'b01, 1'b1);
        @(negedge aclk);
        chk("t6_latency_tvalid", tx2.tvalid, 1);
        chk("t6_seg0_no_stale", tx2.tdata, 32'h66666666);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
